// File: rtl/ibus_arb_pkg.sv
// ibus_arb_pkg: shared types and constants for the two-master ibus arbiter.
//   arb_state_e : arbiter FSM states (idle, owned by m0, owned by m1, handover)
//   OWN_M0/M1   : owner tag values carried in the read tag pipeline
//   IBUS_AW/DW  : ibus word-address and data widths
//   own_state() : maps an owner tag to its ownership state
package ibus_arb_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StOwn0 = 2'd1,
    StOwn1 = 2'd2,
    StHand = 2'd3
  } arb_state_e;

  localparam logic OWN_M0 = 1'b0;
  localparam logic OWN_M1 = 1'b1;

  localparam int unsigned IBUS_AW = 18;
  localparam int unsigned IBUS_DW = 16;

  function automatic arb_state_e own_state(input logic owner);
    return (owner == OWN_M1) ? StOwn1 : StOwn0;
  endfunction

endpackage

// File: rtl/ibus_rd_tag_pipe.sv
// ibus_rd_tag_pipe: DEPTH-stage shift register of {valid, owner} that follows each forwarded
// read through the slave latency, so returning data can be steered to the master that issued it.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low clear (drops all in-flight tags)
//   push_valid  : a read is forwarded to the slave this cycle
//   push_owner  : owner tag of that read
//   pop_valid   : a read issued DEPTH cycles ago returns this cycle
//   pop_owner   : owner tag of the returning read
module ibus_rd_tag_pipe
  import ibus_arb_pkg::*;
#(
  parameter int unsigned DEPTH = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic push_valid,
  input  logic push_owner,
  output logic pop_valid,
  output logic pop_owner
);

  logic valid_q [DEPTH];
  logic owner_q [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        valid_q[i] <= 1'b0;
        owner_q[i] <= OWN_M0;
      end
    end else begin
      valid_q[0] <= push_valid;
      owner_q[0] <= push_valid ? push_owner : OWN_M0;
      for (int i = 1; i < DEPTH; i++) begin
        valid_q[i] <= valid_q[i-1];
        owner_q[i] <= owner_q[i-1];
      end
    end
  end

  assign pop_valid = valid_q[DEPTH-1];
  assign pop_owner = owner_q[DEPTH-1];

endmodule

// File: rtl/ibus_arb2.sv
// ibus_arb2: round-robin arbiter with burst limit sharing the systolic array's 16-bit ibus
// between two masters (m0, m1). The owner's strobes, addresses and write data are muxed
// combinationally onto ibus_*; read data is routed back through a latency-matched tag pipe.
// Optional feature macro: IBUS_ARB_TIMEOUT_EN (idle-owner watchdog, sticky arb_timeout_err).
// Ports (x = 0, 1):
//   clk, rst_n              : clock, asynchronous active-low reset
//   mx_req                  : level request for bus ownership
//   mx_ren, mx_wen          : read/write strobes, honoured only while mx_gnt
//   mx_radr, mx_wadr        : word addresses [19:2]
//   mx_wdata                : write data
//   mx_gnt                  : registered ownership grant
//   mx_rvalid, mx_rdata     : read return for master x (rdata zero when not valid)
//   ibus_ren/wen/radr/wadr/wdata : slave-side command outputs
//   ibus_rdata              : slave read data, valid RD_LAT cycles after ibus_ren
//   arb_timeout_err         : sticky watchdog flag (tied low without IBUS_ARB_TIMEOUT_EN)
module ibus_arb2
  import ibus_arb_pkg::*;
#(
  parameter int unsigned RD_LAT    = 1,
  parameter int unsigned MAX_BURST = 8,
  parameter int unsigned TIMEOUT   = 64
) (
  input  logic               clk,
  input  logic               rst_n,
  // master 0
  input  logic               m0_req,
  input  logic               m0_ren,
  input  logic               m0_wen,
  input  logic [IBUS_AW+1:2] m0_radr,
  input  logic [IBUS_AW+1:2] m0_wadr,
  input  logic [IBUS_DW-1:0] m0_wdata,
  output logic               m0_gnt,
  output logic               m0_rvalid,
  output logic [IBUS_DW-1:0] m0_rdata,
  // master 1
  input  logic               m1_req,
  input  logic               m1_ren,
  input  logic               m1_wen,
  input  logic [IBUS_AW+1:2] m1_radr,
  input  logic [IBUS_AW+1:2] m1_wadr,
  input  logic [IBUS_DW-1:0] m1_wdata,
  output logic               m1_gnt,
  output logic               m1_rvalid,
  output logic [IBUS_DW-1:0] m1_rdata,
  // slave side
  output logic               ibus_ren,
  output logic               ibus_wen,
  output logic [IBUS_AW+1:2] ibus_radr,
  output logic [IBUS_AW+1:2] ibus_wadr,
  output logic [IBUS_DW-1:0] ibus_wdata,
  input  logic [IBUS_DW-1:0] ibus_rdata,
  output logic               arb_timeout_err
);

  if (RD_LAT < 1 || RD_LAT > 4 || MAX_BURST == 0 || TIMEOUT == 0) begin : g_param_err
    $error("ibus_arb2: RD_LAT must be 1..4, MAX_BURST and TIMEOUT must be nonzero");
  end

  localparam int unsigned BcntW = $clog2(MAX_BURST + 1);
  localparam logic [BcntW-1:0] BurstMax = BcntW'(MAX_BURST);

  arb_state_e       state_q, state_d;
  logic             last_q, last_d;   // last owner; breaks ties in idle
  logic             cur_q, cur_d;     // current (or, in handover, outgoing) owner
  logic [BcntW-1:0] bcnt_q, bcnt_d;
  logic             gnt0_q, gnt1_q;

  logic owning, own_req, oth_req, own_cmd, accept;
  logic timeout_hit;

  assign owning  = (state_q == StOwn0) || (state_q == StOwn1);
  assign own_req = (cur_q == OWN_M1) ? m1_req : m0_req;
  assign oth_req = (cur_q == OWN_M1) ? m0_req : m1_req;
  assign own_cmd = (cur_q == OWN_M1) ? (m1_ren | m1_wen) : (m0_ren | m0_wen);
  assign accept  = owning && own_cmd;

  // ---------------------------------------------------------------------------------------------
  // Ownership FSM
  // ---------------------------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    cur_d   = cur_q;
    bcnt_d  = bcnt_q;
    unique case (state_q)
      StIdle: begin
        if (m0_req && m1_req) begin
          cur_d   = ~last_q;
          state_d = own_state(~last_q);
        end else if (m0_req) begin
          cur_d   = OWN_M0;
          state_d = StOwn0;
        end else if (m1_req) begin
          cur_d   = OWN_M1;
          state_d = StOwn1;
        end
      end
      StOwn0, StOwn1: begin
        if (accept && (bcnt_q != BurstMax)) begin
          bcnt_d = bcnt_q + 1'b1;
        end
        // Use the post-accept count so the limiting command is the last one granted.
        if (!own_req || ((bcnt_d == BurstMax) && oth_req) || timeout_hit) begin
          state_d = StHand;
        end
      end
      StHand: begin
        last_d = cur_q;
        bcnt_d = '0;
        if (oth_req) begin
          cur_d   = ~cur_q;
          state_d = own_state(~cur_q);
        end else if (own_req) begin
          state_d = own_state(cur_q);
        end else begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      last_q  <= OWN_M1;  // m0 wins the first tie
      cur_q   <= OWN_M0;
      bcnt_q  <= '0;
      gnt0_q  <= 1'b0;
      gnt1_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      cur_q   <= cur_d;
      bcnt_q  <= bcnt_d;
      gnt0_q  <= (state_d == StOwn0);
      gnt1_q  <= (state_d == StOwn1);
    end
  end

  assign m0_gnt = gnt0_q;
  assign m1_gnt = gnt1_q;

  // ---------------------------------------------------------------------------------------------
  // Idle-owner watchdog
  // ---------------------------------------------------------------------------------------------
`ifdef IBUS_ARB_TIMEOUT_EN
  localparam int unsigned TcntW = $clog2(TIMEOUT + 1);
  localparam logic [TcntW-1:0] TcntMax = TcntW'(TIMEOUT);

  logic [TcntW-1:0] tcnt_q, tcnt_d;
  logic             err_q, err_d;

  always_comb begin
    tcnt_d      = '0;
    timeout_hit = 1'b0;
    if (owning && !accept && oth_req) begin
      tcnt_d      = tcnt_q + 1'b1;
      timeout_hit = (tcnt_d == TcntMax);
    end
    err_d = err_q | timeout_hit;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tcnt_q <= '0;
      err_q  <= 1'b0;
    end else begin
      tcnt_q <= (state_d == StHand) ? '0 : tcnt_d;
      err_q  <= err_d;
    end
  end

  assign arb_timeout_err = err_q;
`else
  assign timeout_hit     = 1'b0;
  assign arb_timeout_err = 1'b0;
`endif

  // ---------------------------------------------------------------------------------------------
  // Slave-side command mux (zero added latency)
  // ---------------------------------------------------------------------------------------------
  always_comb begin
    ibus_ren   = 1'b0;
    ibus_wen   = 1'b0;
    ibus_radr  = '0;
    ibus_wadr  = '0;
    ibus_wdata = '0;
    unique case (state_q)
      StOwn0: begin
        ibus_ren   = m0_ren;
        ibus_wen   = m0_wen;
        ibus_radr  = m0_radr;
        ibus_wadr  = m0_wadr;
        ibus_wdata = m0_wdata;
      end
      StOwn1: begin
        ibus_ren   = m1_ren;
        ibus_wen   = m1_wen;
        ibus_radr  = m1_radr;
        ibus_wadr  = m1_wadr;
        ibus_wdata = m1_wdata;
      end
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------------------------
  // Read return routing
  // ---------------------------------------------------------------------------------------------
  logic tag_valid, tag_owner;

  ibus_rd_tag_pipe #(
    .DEPTH (RD_LAT)
  ) u_tag_pipe (
    .clk        (clk),
    .rst_n      (rst_n),
    .push_valid (ibus_ren),
    .push_owner (cur_q),
    .pop_valid  (tag_valid),
    .pop_owner  (tag_owner)
  );

  assign m0_rvalid = tag_valid && (tag_owner == OWN_M0);
  assign m1_rvalid = tag_valid && (tag_owner == OWN_M1);
  assign m0_rdata  = m0_rvalid ? ibus_rdata : '0;
  assign m1_rdata  = m1_rvalid ? ibus_rdata : '0;

endmodule

// File: tb/tb_ibus_arb2.sv
module tb_ibus_arb2;

  localparam int RD_LAT    = 3;
  localparam int MAX_BURST = 8;
  localparam int TIMEOUT   = 64;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // master-side stimulus, indexed by master
  logic        m_req [2];
  logic        m_ren [2];
  logic        m_wen [2];
  logic [17:0] m_radr [2];
  logic [17:0] m_wadr [2];
  logic [15:0] m_wdata [2];

  logic        gnt0, gnt1, rv0, rv1;
  logic [15:0] rd0, rd1;
  logic        ibus_ren, ibus_wen, err;
  logic [17:0] ibus_radr, ibus_wadr;
  logic [15:0] ibus_wdata;
  logic [15:0] ibus_rdata;

  ibus_arb2 #(
    .RD_LAT    (RD_LAT),
    .MAX_BURST (MAX_BURST),
    .TIMEOUT   (TIMEOUT)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .m0_req          (m_req[0]),
    .m0_ren          (m_ren[0]),
    .m0_wen          (m_wen[0]),
    .m0_radr         (m_radr[0]),
    .m0_wadr         (m_wadr[0]),
    .m0_wdata        (m_wdata[0]),
    .m0_gnt          (gnt0),
    .m0_rvalid       (rv0),
    .m0_rdata        (rd0),
    .m1_req          (m_req[1]),
    .m1_ren          (m_ren[1]),
    .m1_wen          (m_wen[1]),
    .m1_radr         (m_radr[1]),
    .m1_wadr         (m_wadr[1]),
    .m1_wdata        (m_wdata[1]),
    .m1_gnt          (gnt1),
    .m1_rvalid       (rv1),
    .m1_rdata        (rd1),
    .ibus_ren        (ibus_ren),
    .ibus_wen        (ibus_wen),
    .ibus_radr       (ibus_radr),
    .ibus_wadr       (ibus_wadr),
    .ibus_wdata      (ibus_wdata),
    .ibus_rdata      (ibus_rdata),
    .arb_timeout_err (err)
  );

  int n_vec = 0;
  int n_bad = 0;
  int cyc   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // ---------------------------------------------------------------------------------------------
  // Array (slave) model driven by the DUT's ibus outputs; read-before-write in one cycle
  // ---------------------------------------------------------------------------------------------
  logic [15:0] slv_mem [int];
  logic [15:0] slv_pipe [RD_LAT];
  logic        cap_ren, cap_wen;
  logic [17:0] cap_radr, cap_wadr;
  logic [15:0] cap_wdata;

  function automatic logic [15:0] init_val(input logic [17:0] a);
    return a[15:0] ^ 16'h5A5A;
  endfunction

  function automatic logic [15:0] slv_read(input logic [17:0] a);
    if (slv_mem.exists(int'(a))) return slv_mem[int'(a)];
    return init_val(a);
  endfunction

  task automatic slave_update();
    for (int i = RD_LAT - 1; i > 0; i--) slv_pipe[i] = slv_pipe[i-1];
    slv_pipe[0] = cap_ren ? slv_read(cap_radr) : 16'hDEAD;
    if (cap_wen) slv_mem[int'(cap_wadr)] = cap_wdata;
    ibus_rdata = slv_pipe[RD_LAT-1];
  endtask

  // ---------------------------------------------------------------------------------------------
  // Reference model: who owns the bus, what phase, and a queue of pending read returns
  // ---------------------------------------------------------------------------------------------
  typedef struct {
    int          due;
    int          owner;
    logic [15:0] data;
  } rd_t;

  rd_t         pend [$];
  logic [15:0] ref_mem [int];
  int          ph;        // 0 nobody, 1 owned, 2 dead handover cycle
  int          who;       // current / outgoing owner
  int          last_own;
  int          bursts;
  int          idle_cnt;
  bit          m_err;

  function automatic logic [15:0] ref_read(input logic [17:0] a);
    if (ref_mem.exists(int'(a))) return ref_mem[int'(a)];
    return init_val(a);
  endfunction

  task automatic model_reset();
    ph = 0; who = 0; last_own = 1; bursts = 0; idle_cnt = 0; m_err = 1'b0;
    pend.delete();
  endtask

  task automatic check_outputs();
    logic e_ren, e_wen, ev0, ev1;
    logic [15:0] edata;
    e_ren = (ph == 1) ? m_ren[who] : 1'b0;
    e_wen = (ph == 1) ? m_wen[who] : 1'b0;
    chk("m0_gnt", 32'(gnt0), 32'(ph == 1 && who == 0));
    chk("m1_gnt", 32'(gnt1), 32'(ph == 1 && who == 1));
    chk("ibus_ren", 32'(ibus_ren), 32'(e_ren));
    chk("ibus_wen", 32'(ibus_wen), 32'(e_wen));
    if (e_ren) chk("ibus_radr", 32'(ibus_radr), 32'(m_radr[who]));
    if (e_wen) begin
      chk("ibus_wadr", 32'(ibus_wadr), 32'(m_wadr[who]));
      chk("ibus_wdata", 32'(ibus_wdata), 32'(m_wdata[who]));
    end
    ev0 = 1'b0; ev1 = 1'b0; edata = '0;
    if (pend.size() > 0 && pend[0].due == cyc) begin
      ev0 = (pend[0].owner == 0);
      ev1 = (pend[0].owner == 1);
      edata = pend[0].data;
    end
    chk("m0_rvalid", 32'(rv0), 32'(ev0));
    chk("m1_rvalid", 32'(rv1), 32'(ev1));
    if (ev0) chk("m0_rdata", 32'(rd0), 32'(edata));
    if (ev1) chk("m1_rdata", 32'(rd1), 32'(edata));
    chk("arb_timeout_err", 32'(err), 32'(m_err));
    cap_ren = ibus_ren; cap_wen = ibus_wen;
    cap_radr = ibus_radr; cap_wadr = ibus_wadr; cap_wdata = ibus_wdata;
  endtask

  task automatic model_update();
    int o, p;
    bit acc, timed;
    if (pend.size() > 0 && pend[0].due == cyc) void'(pend.pop_front());
    case (ph)
      0: begin
        if (m_req[0] && m_req[1]) begin
          who = (last_own == 1) ? 0 : 1; ph = 1;
        end else if (m_req[0]) begin
          who = 0; ph = 1;
        end else if (m_req[1]) begin
          who = 1; ph = 1;
        end
      end
      1: begin
        o = who; p = 1 - who;
        acc = m_ren[o] | m_wen[o];
        if (m_ren[o]) pend.push_back('{due: cyc + RD_LAT, owner: o, data: ref_read(m_radr[o])});
        if (m_wen[o]) ref_mem[int'(m_wadr[o])] = m_wdata[o];
        if (acc && bursts < MAX_BURST) bursts++;
        timed = 1'b0;
`ifdef IBUS_ARB_TIMEOUT_EN
        if (acc || !m_req[p]) idle_cnt = 0;
        else idle_cnt++;
        if (idle_cnt >= TIMEOUT) begin
          timed = 1'b1; m_err = 1'b1;
        end
`endif
        if (!m_req[o] || (bursts == MAX_BURST && m_req[p]) || timed) begin
          ph = 2; idle_cnt = 0;
        end
      end
      default: begin
        last_own = who; bursts = 0;
        if (m_req[1-who]) begin
          who = 1 - who; ph = 1;
        end else if (m_req[who]) begin
          ph = 1;
        end else begin
          ph = 0;
        end
      end
    endcase
    cyc++;
  endtask

  // Called at a falling edge with inputs already applied.
  task automatic step();
    #2;
    check_outputs();
    @(posedge clk);
    model_update();
    slave_update();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_m0_gnt", 32'(gnt0), 32'd0);
    chk("rst_m1_gnt", 32'(gnt1), 32'd0);
    chk("rst_m0_rvalid", 32'(rv0), 32'd0);
    chk("rst_m1_rvalid", 32'(rv1), 32'd0);
    chk("rst_ibus_ren", 32'(ibus_ren), 32'd0);
    chk("rst_ibus_wen", 32'(ibus_wen), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    model_reset();
    for (int i = 0; i < RD_LAT; i++) slv_pipe[i] = 16'hDEAD;
    ibus_rdata = 16'hDEAD;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic idle_inputs();
    for (int x = 0; x < 2; x++) begin
      m_ren[x] = 1'b0; m_wen[x] = 1'b0;
      m_radr[x] = '0; m_wadr[x] = '0; m_wdata[x] = '0;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    for (int x = 0; x < 2; x++) m_req[x] = 1'b0;
    idle_inputs();
    ibus_rdata = '0;
    model_reset();
    @(negedge clk);
    do_reset();

    // simultaneous requests: m0 wins, then burst of 8 reads while m1 waits
    m_req[0] = 1'b1; m_req[1] = 1'b1;
    step();
    for (int i = 0; i < 8; i++) begin
      m_ren[0]  = 1'b1;
      m_radr[0] = 18'h100 + 18'(i);
      m_wen[1]  = (i == 3);           // not granted: must be dropped
      m_wadr[1] = 18'h103;
      m_wdata[1] = 16'hBAD0;
      step();
    end
    idle_inputs();
    step();                           // handover cycle
    m_ren[1] = 1'b1; m_radr[1] = 18'h103;
    step();                           // m1 granted, reads the untouched word
    m_radr[1] = 18'h104;
    step();
    m_ren[1] = 1'b0;
    repeat (4) step();

    // reset with two m1 reads in flight
    m_ren[1] = 1'b1; m_radr[1] = 18'h105;
    step();
    m_radr[1] = 18'h106;
    step();
    do_reset();
    idle_inputs();
    repeat (6) step();

`ifdef IBUS_ARB_TIMEOUT_EN
    // m0 holds the bus silently while m1 waits
    repeat (TIMEOUT + 6) step();
    chk("timeout_sticky", 32'(err), 32'd1);
`endif

    // randomized traffic
    repeat (3000) begin
      for (int x = 0; x < 2; x++) begin
        if (m_req[x]) m_req[x] = ($urandom_range(15) != 0);
        else m_req[x] = ($urandom_range(3) == 0);
        m_ren[x]   = 1'($urandom_range(1));
        m_wen[x]   = ($urandom_range(3) == 0);
        m_radr[x]  = 18'h100 + 18'($urandom_range(15));
        m_wadr[x]  = 18'h100 + 18'($urandom_range(15));
        m_wdata[x] = 16'($urandom);
      end
      step();
    end

    m_req[0] = 1'b0; m_req[1] = 1'b0;
    idle_inputs();
    repeat (RD_LAT + 3) step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
